// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one external combinational barrel shifter
// between two requesters using a registered req/gnt/done handshake.
module shifter_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic [AMT_W-1:0] amt0,
  input  logic             left0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic [AMT_W-1:0] amt1,
  input  logic             left1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [WIDTH-1:0] sh_string,
  output logic [AMT_W-1:0] sh_amount,
  output logic             sh_left,
  input  logic [WIDTH-1:0] sh_r
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] sh_string_q, sh_string_d;
  logic [AMT_W-1:0] sh_amount_q, sh_amount_d;
  logic             sh_left_q, sh_left_d;
  logic             win;

  // Winner when both request is the side rr_q points at
  assign win = req1 & (~req0 | rr_q);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    result_d    = result_q;
    sh_string_d = sh_string_q;
    sh_amount_d = sh_amount_q;
    sh_left_d   = sh_left_q;
    case (state_q)
      IDLE, DONE: begin
        if (req0 | req1) begin
          state_d     = EXEC;
          owner_d     = win;
          rr_d        = ~win;
          gnt0_d      = ~win;
          gnt1_d      = win;
          sh_string_d = win ? data1 : data0;
          sh_amount_d = win ? amt1 : amt0;
          sh_left_d   = win ? left1 : left0;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d  = DONE;
        result_d = sh_r;
        done0_d  = ~owner_q;
        done1_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      sh_string_q <= '0;
      sh_amount_q <= '0;
      sh_left_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      sh_string_q <= sh_string_d;
      sh_amount_q <= sh_amount_d;
      sh_left_q   <= sh_left_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign sh_string = sh_string_q;
  assign sh_amount = sh_amount_q;
  assign sh_left   = sh_left_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter with a behavioural barrel shifter model.
module tb_shifter_arbiter;

  logic        clk, reset;
  logic        req0, left0, req1, left1;
  logic [15:0] data0, data1;
  logic [3:0]  amt0, amt1;
  logic        gnt0, gnt1, done0, done1, busy, sh_left;
  logic [15:0] result, sh_string, sh_r;
  logic [3:0]  sh_amount;

  int errors = 0;
  int checks = 0;

  shifter_arbiter #(.WIDTH(16), .AMT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .amt0(amt0), .left0(left0),
    .req1(req1), .data1(data1), .amt1(amt1), .left1(left1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy),
    .sh_string(sh_string), .sh_amount(sh_amount), .sh_left(sh_left),
    .sh_r(sh_r)
  );

  // Reference shifter the arbiter drives
  assign sh_r = sh_left ? (sh_string << sh_amount) : (sh_string >> sh_amount);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs the handshake outputs as {gnt0,gnt1,done0,done1,busy}
  function automatic logic [31:0] hs();
    return {27'd0, gnt0, gnt1, done0, done1, busy};
  endfunction

  initial begin
    reset = 1'b1;
    req0 = 0; data0 = '0; amt0 = '0; left0 = 0;
    req1 = 0; data1 = '0; amt1 = '0; left1 = 0;
    tick(); tick();
    check("reset_hs", hs(), 32'b00000);
    check("reset_result", 32'(result), 32'h0);
    check("reset_sh", {15'd0, sh_left, sh_amount, sh_string}, 32'h0);
    reset = 1'b0;

    // Reset while in EXEC discards the operation
    req0 = 1; data0 = 16'h00F1; amt0 = 4'd4; left0 = 1;
    tick();
    check("t1_gnt0", hs(), 32'b10001);
    check("t1_sh", {15'd0, sh_left, sh_amount, sh_string}, {15'd0, 1'b1, 4'd4, 16'h00F1});
    req0 = 0;
    reset = 1'b1;
    #1;
    check("t1_async_hs", hs(), 32'b00000);
    check("t1_async_sh", {15'd0, sh_left, sh_amount, sh_string}, 32'h0);
    check("t1_async_result", 32'(result), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("t1_no_done", hs(), 32'b00000);

    // Both requesting after reset: req0 first, then alternate
    req0 = 1; data0 = 16'h0001; amt0 = 4'd1; left0 = 1;
    req1 = 1; data1 = 16'h0010; amt1 = 4'd2; left1 = 0;
    tick(); check("t4_c1", hs(), 32'b10001);
    tick(); check("t4_c2", hs(), 32'b00101);
    check("t4_res0", 32'(result), 32'h0002);
    tick(); check("t4_c3", hs(), 32'b01001);
    tick(); check("t4_c4", hs(), 32'b00011);
    check("t4_res1", 32'(result), 32'h0004);
    tick(); check("t4_c5", hs(), 32'b10001);
    req0 = 0; req1 = 0;
    tick(); check("t4_c6", hs(), 32'b00101);
    check("t4_res2", 32'(result), 32'h0002);
    tick(); check("t4_idle", hs(), 32'b00000);
    check("t4_hold", 32'(result), 32'h0002);

    // Single req0
    req0 = 1; data0 = 16'h00F1; amt0 = 4'd4; left0 = 1;
    tick(); check("t2_gnt", hs(), 32'b10001);
    req0 = 0; data0 = 16'hFFFF;
    tick(); check("t2_done", hs(), 32'b00101);
    check("t2_res", 32'(result), 32'h0F10);
    tick(); check("t2_idle", hs(), 32'b00000);

    // Single req1, full right shift then zero amount
    req1 = 1; data1 = 16'h8000; amt1 = 4'd15; left1 = 0;
    tick(); check("t3a_gnt", hs(), 32'b01001);
    req1 = 0;
    tick(); check("t3a_done", hs(), 32'b00011);
    check("t3a_res", 32'(result), 32'h0001);
    tick();
    req1 = 1; data1 = 16'hA5A5; amt1 = 4'd0; left1 = 0;
    tick(); check("t3b_gnt", hs(), 32'b01001);
    req1 = 0;
    tick(); check("t3b_done", hs(), 32'b00011);
    check("t3b_res", 32'(result), 32'hA5A5);
    tick(); check("t3b_idle", hs(), 32'b00000);

    // DONE straight to EXEC for a new requester
    req1 = 1; data1 = 16'h00FF; amt1 = 4'd4; left1 = 0;
    tick(); check("t5_gnt1", hs(), 32'b01001);
    req1 = 0;
    tick(); check("t5_done1", hs(), 32'b00011);
    check("t5_res1", 32'(result), 32'h000F);
    req0 = 1; data0 = 16'h0003; amt0 = 4'd2; left0 = 1;
    tick(); check("t5_gnt0_direct", hs(), 32'b10001);
    req0 = 0;
    tick(); check("t5_done0", hs(), 32'b00101);
    check("t5_res0", 32'(result), 32'h000C);
    req0 = 1; req1 = 1;
    tick(); check("t5_rr_after", hs(), 32'b01001);
    req0 = 0; req1 = 0;
    tick(); check("t5_done1b", hs(), 32'b00011);
    check("t5_res1b", 32'(result), 32'h000F);
    tick(); check("t5_idle", hs(), 32'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
- Shares the single 16-bit combinational barrel shifter between two requesters, e.g. port 0 = ALU/instruction path and port 1 = load/store byte-alignment unit.
- Round-robin arbitration with a registered req/gnt/done handshake.
- Drives the shifter's operand, amount and direction inputs from registers, and captures the shifter result into a result register.
- Sits between the requesters and the shifter instance in the datapath.

Parameters:
- WIDTH, 16, data width of operand and result; must match the shifter.
- AMT_W, 4, shift-amount width; must match the shifter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 wants a shift
- data0  in  WIDTH  requester 0 operand
- amt0  in  AMT_W  requester 0 shift amount
- left0  in  1  requester 0 direction: 1 = logical left, 0 = logical right
- req1  in  1  requester 1 wants a shift
- data1  in  WIDTH  requester 1 operand
- amt1  in  AMT_W  requester 1 shift amount
- left1  in  1  requester 1 direction
- gnt0  out  1  one-cycle pulse: requester 0 operands accepted
- gnt1  out  1  one-cycle pulse: requester 1 operands accepted
- done0  out  1  one-cycle pulse: result valid for requester 0
- done1  out  1  one-cycle pulse: result valid for requester 1
- result  out  WIDTH  registered shift result
- busy  out  1  high whenever state != IDLE
- sh_string  out  WIDTH  registered operand to the shifter
- sh_amount  out  AMT_W  registered amount to the shifter
- sh_left  out  1  registered direction to the shifter
- sh_r  in  WIDTH  combinational result from the shifter

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE; rr_ptr = 0.
  - gnt0, gnt1, done0, done1, busy all 0.
  - result = 0; sh_string = 0; sh_amount = 0; sh_left = 0.
  - An in-flight operation is discarded; no done pulse is issued for it.
- States: IDLE, EXEC, DONE. All outputs are registered (Moore).
- Arbitration happens on a clock edge while in IDLE or DONE:
  - Only one of req0/req1 high -> grant that requester.
  - Both high -> grant the side rr_ptr points to (0 = req0 first).
  - After a grant to side X, rr_ptr = not X. rr_ptr changes only on a grant.
  - No request -> IDLE to IDLE; DONE to IDLE.
- On a granting edge:
  - Load sh_string/sh_amount/sh_left from the winner's data/amt/left.
  - Set gnt of the winner for exactly one cycle; go to EXEC.
- In EXEC:
  - sh_* outputs are held stable.
  - On the next edge: result <= sh_r; done of the owner = 1 for one cycle; state = DONE.
- In DONE:
  - done is high and result is valid.
  - Arbitration happens on this state's exit edge (rules above).
- result holds its value until the next EXEC-to-DONE edge.
- Latency: req sampled at edge E0 -> gnt high after E0 -> done high and result valid after E1, i.e. 2 cycles.
- Throughput: one operation per 2 cycles with back-to-back requests (DONE to EXEC directly).
- Requester rules:
  - Hold req and operands stable until gnt is seen.
  - Drop req in the cycle following gnt unless another operation is wanted.
  - req still high at the DONE exit edge counts as a new request.
  - Operands may change after gnt; they are captured at the granting edge.
- gnt0/gnt1 are never high together; done0/done1 are never high together.
- amt = 0 passes the operand unchanged. Bits shifted out are lost; vacated bits are 0.

Test Plan:
- Reset mid-EXEC (req0 granted, assert reset while in EXEC) -> all outputs 0 immediately; no done0 follows; next req0 is serviced normally with rr_ptr = 0.
- req0 only, data0 = 16'h00F1, amt0 = 4, left0 = 1 -> gnt0 one cycle after the sampling edge, done0 one cycle later, result = 16'h0F10.
- req1 only, data1 = 16'h8000, amt1 = 15, left1 = 0 -> done1 with result = 16'h0001; then amt1 = 0, data1 = 16'hA5A5 -> result = 16'hA5A5.
- req0 and req1 high together after reset, both held, left0 = 1, amt0 = 1, data0 = 1; left1 = 0, amt1 = 2, data1 = 16'h0010:
  - Grants alternate gnt0, gnt1, gnt0 on cycles 1, 3, 5.
  - Results are 16'h0002 and 16'h0004.
  - busy stays high throughout.
- req1 drops after gnt1 while req0 rises in the DONE cycle -> gnt0 issued directly from DONE with no IDLE cycle; rr_ptr = 1 afterwards.
